// File: rtl/mux15_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux15_rr_arbiter
//
// Purpose:
//   This is a round-robin arbiter for the shared 15:1, 32-bit selection mux.
//   One requester owns the mux at a time. Ownership ends when the owner pulses
//   done, drops its request, or reaches MAX_HOLD cycles. In that last case the
//   grant is revoked by force.
//   Every release is followed by exactly one dead cycle (GAP). During GAP the
//   round-robin pointer moves past the previous owner before the next search.
//
// Parameters:
//   MAX_HOLD  maximum number of consecutive cycles one owner may hold the grant
//             (legal range 1..255)
//   CNT_W     width of the hold counter; 2**CNT_W must exceed MAX_HOLD
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   req[14:0]  request vector; bit i means requester i wants the mux
//   done       one-cycle release pulse from the current owner
//   gnt[14:0]  one-hot grant; all zero when there is no owner
//   sel[3:0]   mux select, equal to the owner index (0..14); 14 after reset
//   gnt_valid  high while an owner holds the grant
//   timeout    one-cycle pulse during the GAP that follows a forced revoke
// -----------------------------------------------------------------------------
module mux15_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] req,
  input  logic        done,
  output logic [14:0] gnt,
  output logic [3:0]  sel,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           r_state,   w_state_nxt;
  logic [14:0]      r_gnt,     w_gnt_nxt;
  logic [3:0]       r_sel,     w_sel_nxt;     // also serves as the owner index
  logic             r_valid,   w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [3:0]       r_ptr,     w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;

  // Round-robin search: find the first set request bit, starting at r_ptr and
  // wrapping from 14 back to 0.
  logic       w_found;
  logic [3:0] w_win;
  logic [4:0] w_sum;
  logic [3:0] w_idx;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path through the block leaves it unassigned (which would infer a latch).
    w_found = 1'b0;
    w_win   = 4'd0;
    w_sum   = 5'd0;
    w_idx   = 4'd0;
    for (int i = 0; i < 15; i++) begin
      w_sum = {1'b0, r_ptr} + 5'(i);
      w_idx = (w_sum >= 5'd15) ? 4'(w_sum - 5'd15) : w_sum[3:0];
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  logic w_hit_limit;
  logic w_owner_req;

  assign w_hit_limit = (r_cnt == CNT_W'(MAX_HOLD));
  assign w_owner_req = req[r_sel];

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;

    case (r_state)
      ST_IDLE, ST_GAP: begin
        // done is ignored here; sel keeps its last value until a new grant.
        if (w_found) begin
          w_state_nxt = ST_OWN;
          w_gnt_nxt   = 15'd1 << w_win;
          w_sel_nxt   = w_win;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      end

      ST_OWN: begin
        if (done || !w_owner_req || w_hit_limit) begin
          w_state_nxt   = ST_GAP;
          w_gnt_nxt     = '0;
          w_valid_nxt   = 1'b0;
          w_cnt_nxt     = '0;
          w_ptr_nxt     = (r_sel == 4'd14) ? 4'd0 : r_sel + 4'd1;
          // A voluntary release on the limit cycle takes precedence over the
          // forced revoke.
          w_timeout_nxt = w_hit_limit && !done && w_owner_req;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        // Illegal encoding: return to IDLE with the reset output values.
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_sel_nxt   = 4'd14;
        w_valid_nxt = 1'b0;
        w_ptr_nxt   = 4'd0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: non-blocking assignments in clocked blocks make all registers
      // update together from the values they held before the edge.
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt     <= '0;
      r_sel     <= 4'd14;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= 4'd0;
      r_cnt     <= '0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign gnt_valid = r_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_mux15_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux15_rr_arbiter
//
// Self-checking bench for mux15_rr_arbiter. The arbiter is built with
// MAX_HOLD = 4, which keeps forced revokes short.
//
// The bench runs, in order:
//   - a vector table covering reset, a full rotation with wrap, pointer
//     movement, and done being ignored while idle;
//   - hand-written sequences for timeout, request drop, the done/limit tie,
//     and asynchronous reset while a grant is held;
//   - randomized traffic compared against a cycle-level ownership model.
// -----------------------------------------------------------------------------
module tb_mux15_rr_arbiter;

  localparam int unsigned MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] req;
  logic        done;
  logic [14:0] gnt;
  logic [3:0]  sel;
  logic        gnt_valid;
  logic        timeout;

  always #5 clk = ~clk;

  mux15_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [14:0] eg, input logic [3:0] es,
                           input logic ev, input logic et);
    check($sformatf("%s.gnt", tag),       32'(gnt),       32'(eg));
    check($sformatf("%s.sel", tag),       32'(sel),       32'(es));
    check($sformatf("%s.gnt_valid", tag), 32'(gnt_valid), 32'(ev));
    check($sformatf("%s.timeout", tag),   32'(timeout),   32'(et));
  endtask

  // Outputs are sampled 1 ns after the rising edge. The next inputs are
  // driven at the same moment.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [14:0] rq, input logic dn);
    req  = rq;
    done = dn;
    tick();
  endtask

  task automatic do_reset(input logic [14:0] rq);
    reset_n = 1'b0;
    req     = rq;
    done    = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks who owns the mux, how long the owner has held it,
  // and where the next search starts.
  // ---------------------------------------------------------------------------
  int m_owner;    // -1 when nobody owns the mux
  int m_held;     // cycles the current owner has held the grant
  int m_ptr;
  int m_sel;
  bit m_timeout;

  task automatic model_reset();
    m_owner   = -1;
    m_held    = 0;
    m_ptr     = 0;
    m_sel     = 14;
    m_timeout = 1'b0;
  endtask

  function automatic int model_pick(input logic [14:0] rq);
    for (int k = 0; k < 15; k++) begin
      if (rq[(m_ptr + k) % 15]) return (m_ptr + k) % 15;
    end
    return -1;
  endfunction

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input logic [14:0] rq, input logic dn);
    m_timeout = 1'b0;
    if (m_owner >= 0) begin
      if (dn || !rq[m_owner] || m_held == int'(MAX_HOLD)) begin
        m_timeout = (m_held == int'(MAX_HOLD)) && !dn && rq[m_owner];
        m_ptr     = (m_owner + 1) % 15;
        m_owner   = -1;
        m_held    = 0;
      end else begin
        m_held++;
      end
    end else begin
      m_owner = model_pick(rq);
      if (m_owner >= 0) begin
        m_sel  = m_owner;
        m_held = 1;
      end
    end
  endtask

  typedef struct {
    logic [14:0] req;
    logic        done;
    logic [14:0] gnt;
    logic [3:0]  sel;
    logic        valid;
    logic        tout;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [14:0] rq;

    reset_n = 1'b0;
    req     = '0;
    done    = 1'b0;

    // Vector table. Each entry holds the inputs applied before an edge and the
    // outputs expected after it. Each owner pulses done in its second cycle.
    for (int k = 0; k < 15; k++) begin
      tbl.push_back('{15'h7FFF, 1'b0, 15'd1 << k, 4'(k), 1'b1, 1'b0});
      tbl.push_back('{15'h7FFF, 1'b0, 15'd1 << k, 4'(k), 1'b1, 1'b0});
      tbl.push_back('{(k == 14) ? 15'h0003 : 15'h7FFF, 1'b1, 15'h0000, 4'(k), 1'b0, 1'b0});
    end
    tbl.push_back('{15'h0003, 1'b0, 15'h0001, 4'd0, 1'b1, 1'b0});  // wrap 14 -> 0
    tbl.push_back('{15'h0003, 1'b1, 15'h0000, 4'd0, 1'b0, 1'b0});
    tbl.push_back('{15'h0003, 1'b0, 15'h0002, 4'd1, 1'b1, 1'b0});  // ptr moved to 1
    tbl.push_back('{15'h0000, 1'b1, 15'h0000, 4'd1, 1'b0, 1'b0});
    tbl.push_back('{15'h0000, 1'b0, 15'h0000, 4'd1, 1'b0, 1'b0});  // GAP -> IDLE
    tbl.push_back('{15'h0000, 1'b1, 15'h0000, 4'd1, 1'b0, 1'b0});  // done ignored while idle

    // Reset with every requester asserted.
    do_reset(15'h7FFF);
    check_out("reset", 15'h0000, 4'd14, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].req, tbl[i].done);
      check_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].tout);
    end

    // Timeout: requester 5 alone with done low. It holds for MAX_HOLD cycles,
    // then gets one GAP cycle with timeout high, then is granted again.
    do_reset(15'h0000);
    for (int c = 0; c < int'(MAX_HOLD); c++) begin
      apply(15'h0020, 1'b0);
      check_out($sformatf("tmo_hold%0d", c), 15'h0020, 4'd5, 1'b1, 1'b0);
    end
    apply(15'h0020, 1'b0);
    check_out("tmo_gap", 15'h0000, 4'd5, 1'b0, 1'b1);
    apply(15'h0020, 1'b0);
    check_out("tmo_regrant", 15'h0020, 4'd5, 1'b1, 1'b0);

    // Request drop: owner 3 drops its request in its second cycle.
    do_reset(15'h0000);
    apply(15'h0008, 1'b0);
    check_out("drop_own1", 15'h0008, 4'd3, 1'b1, 1'b0);
    apply(15'h0008, 1'b0);
    check_out("drop_own2", 15'h0008, 4'd3, 1'b1, 1'b0);
    apply(15'h0000, 1'b0);
    check_out("drop_gap", 15'h0000, 4'd3, 1'b0, 1'b0);

    // Tie: done arrives on the same cycle the hold limit is reached, so
    // timeout must stay low.
    for (int c = 0; c < int'(MAX_HOLD); c++) begin
      apply(15'h0008, 1'b0);
      check_out($sformatf("tie_hold%0d", c), 15'h0008, 4'd3, 1'b1, 1'b0);
    end
    apply(15'h0008, 1'b1);
    check_out("tie_gap", 15'h0000, 4'd3, 1'b0, 1'b0);

    // Asynchronous reset while owner 7 holds the grant and ptr is 8.
    do_reset(15'h0000);
    apply(15'h0080, 1'b0);
    apply(15'h0080, 1'b1);                       // release: ptr becomes 8
    apply(15'h0080, 1'b0);
    check_out("mid_own7", 15'h0080, 4'd7, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_out("mid_async", 15'h0000, 4'd14, 1'b0, 1'b0);
    req = 15'h0880;
    tick();
    tick();
    reset_n = 1'b1;
    apply(15'h0880, 1'b0);                       // search restarts at ptr 0
    check_out("mid_regrant", 15'h0080, 4'd7, 1'b1, 1'b0);

    // Randomized traffic against the model. Requests are sticky, so owners
    // often run into the hold limit.
    do_reset(15'h0000);
    model_reset();
    rq = '0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) < 3) begin
        case ($urandom_range(0, 3))
          0:       rq = '0;
          1:       rq = 15'd1 << $urandom_range(0, 14);
          2:       rq = rq ^ (15'd1 << $urandom_range(0, 14));
          default: rq = 15'($urandom);
        endcase
      end
      done = ($urandom_range(0, 4) == 0);
      req  = rq;
      model_edge(req, done);
      tick();
      check_out($sformatf("rnd%0d", c),
                (m_owner >= 0) ? (15'd1 << m_owner) : 15'h0000,
                4'(m_sel), m_owner >= 0, m_timeout);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
